// File: rtl/spatz_vfu_sequencer.sv
// rtl/spatz_vfu_sequencer.sv - Spatz VFU sequencer: group-wise VRF reads, SIMD integer ALU, masked write-back
// One instruction in flight; each element group is read, computed and written before the next is fetched.
module spatz_vfu_sequencer #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned ELEN    = 32,
  parameter int unsigned VLENB   = 32,
  parameter int unsigned NrVRegs = 32,
  localparam int unsigned W           = NrLanes * ELEN,
  localparam int unsigned WB          = W / 8,
  localparam int unsigned WordsPerReg = VLENB / WB,
  localparam int unsigned Depth       = NrVRegs * WordsPerReg,
  localparam int unsigned AddrW       = $clog2(Depth),
  localparam int unsigned VlW         = $clog2(8 * VLENB) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_op_i,
  input  logic [1:0]            req_vsew_i,
  input  logic [VlW-1:0]        req_vl_i,
  input  logic [4:0]            req_vs1_i,
  input  logic [4:0]            req_vs2_i,
  input  logic [4:0]            req_vd_i,
  input  logic                  req_use_vs1_i,
  input  logic [ELEN-1:0]       req_rs1_i,
  output logic [1:0][AddrW-1:0] vrf_raddr_o,
  output logic [1:0]            vrf_re_o,
  input  logic [1:0]            vrf_rvalid_i,
  input  logic [1:0][W-1:0]     vrf_rdata_i,
  output logic [AddrW-1:0]      vrf_waddr_o,
  output logic [W-1:0]          vrf_wdata_o,
  output logic [WB-1:0]         vrf_wbe_o,
  output logic                  vrf_we_o,
  input  logic                  vrf_wvalid_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_err_o,
  input  logic                  rsp_ready_i
);

  localparam int unsigned BlW = VlW + 3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  state_e state_q, state_d;

  logic [2:0]            op_q;
  logic [1:0]            sew_q;
  logic                  use_vs1_q, err_q;
  logic [ELEN-1:0]       rs1_q;
  logic [BlW-1:0]        bytes_left_q;
  logic [1:0]            cap_q;
  logic [1:0][W-1:0]     data_q;
  logic [1:0][AddrW-1:0] raddr_q;
  logic [AddrW-1:0]      waddr_q;
  logic [W-1:0]          wdata_q;
  logic [WB-1:0]         wbe_q;

  logic            got0, got1, grp_done, last_grp;
  logic [W-1:0]    opa, opb, scalar_rep, result;
  logic [WB-1:0]   wbe_n;
  logic [31:0]     tmp;

  function automatic logic [AddrW-1:0] base_addr(input logic [4:0] r);
    return AddrW'(r) * AddrW'(WordsPerReg);
  endfunction

  function automatic logic [AddrW-1:0] next_addr(input logic [AddrW-1:0] a);
    return (a == AddrW'(Depth - 1)) ? '0 : a + 1'b1;
  endfunction

  // Operands arrive MSB-aligned so wrap-around and signed compares at SEW fall out of 32-bit arithmetic.
  function automatic logic [31:0] elem_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? a : b;
      3'd6:    return ($signed(a) > $signed(b)) ? a : b;
      default: return (a < b) ? a : b;
    endcase
  endfunction

  assign vrf_re_o[0] = (state_q == READ) && !cap_q[0];
  assign vrf_re_o[1] = (state_q == READ) && use_vs1_q && !cap_q[1];

  assign got0     = cap_q[0] || (vrf_re_o[0] && vrf_rvalid_i[0]);
  assign got1     = !use_vs1_q || cap_q[1] || (vrf_re_o[1] && vrf_rvalid_i[1]);
  assign grp_done = (state_q == READ) && got0 && got1;
  assign last_grp = bytes_left_q <= BlW'(WB);

  assign req_ready_o = (state_q == IDLE);
  assign vrf_we_o    = (state_q == WRITE);
  assign rsp_valid_o = (state_q == DONE);
  assign rsp_err_o   = (state_q == DONE) && err_q;
  assign vrf_raddr_o = raddr_q;
  assign vrf_waddr_o = waddr_q;
  assign vrf_wdata_o = wdata_q;
  assign vrf_wbe_o   = wbe_q;

  always_comb begin
    case (sew_q)
      2'd0:    scalar_rep = {(W/8){rs1_q[7:0]}};
      2'd1:    scalar_rep = {(W/16){rs1_q[15:0]}};
      default: scalar_rep = {(W/32){rs1_q[31:0]}};
    endcase
    opa = cap_q[0] ? data_q[0] : vrf_rdata_i[0];
    opb = !use_vs1_q ? scalar_rep : (cap_q[1] ? data_q[1] : vrf_rdata_i[1]);
  end

  always_comb begin
    result = '0;
    tmp    = '0;
    wbe_n  = '0;
    case (sew_q)
      2'd0: for (int e = 0; e < int'(W / 8); e++) begin
        tmp = elem_op(op_q, {opa[8*e +: 8], 24'd0}, {opb[8*e +: 8], 24'd0});
        result[8*e +: 8] = tmp[31:24];
      end
      2'd1: for (int e = 0; e < int'(W / 16); e++) begin
        tmp = elem_op(op_q, {opa[16*e +: 16], 16'd0}, {opb[16*e +: 16], 16'd0});
        result[16*e +: 16] = tmp[31:16];
      end
      default: for (int e = 0; e < int'(W / 32); e++) begin
        tmp = elem_op(op_q, opa[32*e +: 32], opb[32*e +: 32]);
        result[32*e +: 32] = tmp;
      end
    endcase
    for (int b = 0; b < int'(WB); b++) wbe_n[b] = BlW'(b) < bytes_left_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid_i) state_d = (req_vsew_i == 2'd3 || req_vl_i == '0) ? DONE : READ;
      READ:  if (grp_done) state_d = WRITE;
      WRITE: if (vrf_wvalid_i) state_d = last_grp ? DONE : READ;
      DONE:  if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q <= '0; sew_q <= '0; use_vs1_q <= 1'b0; err_q <= 1'b0; rs1_q <= '0;
      bytes_left_q <= '0; cap_q <= '0; data_q <= '0; raddr_q <= '0;
      waddr_q <= '0; wdata_q <= '0; wbe_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          op_q         <= req_op_i;
          sew_q        <= req_vsew_i;
          use_vs1_q    <= req_use_vs1_i;
          rs1_q        <= req_rs1_i;
          err_q        <= (req_vsew_i == 2'd3);
          bytes_left_q <= BlW'(req_vl_i) << req_vsew_i;
          raddr_q[0]   <= base_addr(req_vs2_i);
          raddr_q[1]   <= base_addr(req_vs1_i);
          waddr_q      <= base_addr(req_vd_i);
          cap_q        <= '0;
        end
        READ: begin
          for (int p = 0; p < 2; p++) begin
            if (vrf_re_o[p] && vrf_rvalid_i[p]) begin
              data_q[p] <= vrf_rdata_i[p];
              cap_q[p]  <= 1'b1;
            end
          end
          if (grp_done) begin
            wdata_q <= result;
            wbe_q   <= wbe_n;
            cap_q   <= '0;
          end
        end
        WRITE: if (vrf_wvalid_i) begin
          raddr_q[0]   <= next_addr(raddr_q[0]);
          raddr_q[1]   <= next_addr(raddr_q[1]);
          waddr_q      <= next_addr(waddr_q);
          bytes_left_q <= last_grp ? '0 : bytes_left_q - BlW'(WB);
        end
        default: ;
      endcase
    end
  end

endmodule
